// File: rtl/pulse_compressor.sv
// rtl/pulse_compressor.sv - compresses a stretched level pulse to a strobe and classifies its width
module pulse_compressor #(
    parameter int STRX = 8,
    parameter int TOL  = 1,
    parameter int MAXW = 255,
    parameter int CW   = 16,
    localparam int WW  = $clog2(MAXW + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          din,
    input  logic          clr_cnt,
    output logic          pulse_out,
    output logic          busy,
    output logic [WW-1:0] width,
    output logic          width_valid,
    output logic          err_short,
    output logic          err_long,
    output logic [CW-1:0] good_cnt
);

    localparam logic [WW-1:0] W_LO  = WW'(STRX - TOL);
    localparam logic [WW-1:0] W_HI  = WW'(STRX + TOL);
    localparam logic [WW-1:0] W_SAT = WW'(MAXW);

    typedef enum logic [1:0] {
        S_ARM  = 2'd0,
        S_IDLE = 2'd1,
        S_HIGH = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] cnt_q, cnt_d;
    logic          pulse_out_q, pulse_out_d;
    logic          busy_q, busy_d;
    logic [WW-1:0] width_q, width_d;
    logic          width_valid_q, width_valid_d;
    logic          err_short_q, err_short_d;
    logic          err_long_q, err_long_d;
    logic [CW-1:0] good_cnt_q, good_cnt_d;

    logic          report;
    logic          is_short;
    logic          is_long;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_ARM;
        end else begin
            state_q <= state_d;
        end
    end

    // ARM only leaves on a low level, so a line already high at reset is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ARM:   if (!din) state_d = S_IDLE;
            S_IDLE:  if (din)  state_d = S_HIGH;
            S_HIGH:  if (!din) state_d = S_IDLE;
            default: state_d = S_ARM;
        endcase
    end

    assign report   = (state_q == S_HIGH) && !din;
    assign is_short = cnt_q < W_LO;
    assign is_long  = cnt_q > W_HI;

    always_comb begin
        cnt_d         = cnt_q;
        pulse_out_d   = 1'b0;
        busy_d        = (state_d == S_HIGH);
        width_d       = width_q;
        width_valid_d = 1'b0;
        err_short_d   = err_short_q;
        err_long_d    = err_long_q;
        good_cnt_d    = good_cnt_q;

        if (state_q == S_IDLE && din) begin
            cnt_d       = {{(WW-1){1'b0}}, 1'b1};
            pulse_out_d = 1'b1;
        end else if (state_q == S_HIGH && din && cnt_q != W_SAT) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (report) begin
            width_d       = cnt_q;
            width_valid_d = 1'b1;
            err_short_d   = is_short;
            err_long_d    = is_long;
            if (!is_short && !is_long) begin
                good_cnt_d = good_cnt_q + 1'b1;
            end
        end

        // A clear wins over a good report landing on the same edge.
        if (clr_cnt) begin
            good_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q         <= '0;
            pulse_out_q   <= 1'b0;
            busy_q        <= 1'b0;
            width_q       <= '0;
            width_valid_q <= 1'b0;
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
            good_cnt_q    <= '0;
        end else begin
            cnt_q         <= cnt_d;
            pulse_out_q   <= pulse_out_d;
            busy_q        <= busy_d;
            width_q       <= width_d;
            width_valid_q <= width_valid_d;
            err_short_q   <= err_short_d;
            err_long_q    <= err_long_d;
            good_cnt_q    <= good_cnt_d;
        end
    end

    assign pulse_out   = pulse_out_q;
    assign busy        = busy_q;
    assign width       = width_q;
    assign width_valid = width_valid_q;
    assign err_short   = err_short_q;
    assign err_long    = err_long_q;
    assign good_cnt    = good_cnt_q;

endmodule

// File: doc/pulse_compressor.md
# pulse_compressor

Receive-side companion to the pulse stretcher: takes a stretched, clock-synchronous level pulse and compresses it back to a single-cycle event. It measures each pulse's high time and classifies the width against the nominal stretch length. It also keeps a wrap-around count of in-tolerance pulses. It sits at the destination of a stretched-pulse link, such as a slow-domain status line or a pulse-extended interrupt, and feeds event logic and error monitors.

## Interface
- STRX, 8: nominal pulse width in cycles; the stretcher with the same STRX produces exactly STRX high cycles.
- TOL, 1: accepted deviation; a pulse is good when STRX-TOL <= width <= STRX+TOL. Constraint: TOL < STRX.
- MAXW, 255: width counter saturation value. Constraint: STRX+TOL < MAXW.
- CW, 16: good-pulse counter width.
- clk  in  1  rising-edge clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- din  in  1  stretched pulse, synchronous to clk.
- clr_cnt  in  1  synchronous clear of good_cnt.
- pulse_out  out  1  one-cycle strobe marking the start of a pulse.
- busy  out  1  high while a pulse is being measured (state HIGH).
- width  out  WW=$clog2(MAXW+1)  last measured width, saturated at MAXW.
- width_valid  out  1  one-cycle strobe: width and err_* are updated.
- err_short  out  1  qualified by width_valid: width < STRX-TOL.
- err_long  out  1  qualified by width_valid: width > STRX+TOL, including a saturated width.
- good_cnt  out  CW  count of good pulses; wraps modulo 2^CW.

## Operation
- The FSM has three states: ARM, IDLE and HIGH. All outputs are registered.
- ARM is the reset state.
  - ARM waits for din=0, then moves to IDLE. This ensures a level already high at reset release is never measured.
- IDLE:
  - When din=1, move to HIGH, load cnt to 1, and assert pulse_out for one cycle.
- HIGH, while din=1:
  - cnt increments each cycle and saturates at MAXW.
  - The FSM stays in HIGH indefinitely until din falls.
- HIGH, when din=0:
  - width is set to cnt and width_valid=1 for one cycle.
  - err_short and err_long are set per the classification; at most one is ever set.
  - If neither error is set, good_cnt increments. The FSM returns to IDLE.
- err_short and err_long hold their last value between reports and are only meaningful while width_valid is high.
- good_cnt wraps from 2^CW-1 to 0.
- clr_cnt=1 sets good_cnt to 0. If a good report lands on the same cycle, clr_cnt takes priority and good_cnt is 0, not 1.
- Reset, whether at power-up or mid-pulse:
  - Immediately, FSM=ARM and cnt=0.
  - pulse_out, busy, width_valid, err_short and err_long are all 0; width=0 and good_cnt=0.
  - Any partially measured pulse is discarded with no report.

## Timing
- din is sampled at every rising edge of clk.
- Pulse start: let edge k be the first edge that samples din=1 in IDLE.
  - pulse_out and busy are high from edge k.
  - pulse_out drops at edge k+1.
- Pulse end: if din is sampled 1 at edges k..k+W-1 and 0 at edge k+W:
  - At edge k+W, width=min(W,MAXW), width_valid=1 and busy=0.
  - width_valid drops at edge k+W+1.
- Latency is 1 cycle from rising din to pulse_out, and 1 cycle from falling din to the report.
- Back-to-back pulses: a single low cycle is the minimum gap.
  - If edge k+W+1 samples din=1, a new pulse_out asserts on the same edge that width_valid drops.
  - Both pulses are reported correctly.
- A zero-gap pulse (din held high continuously) is one long pulse.
- A width of 1 is legal; with default parameters it reports err_short.
- width holds its value until the next report.

## Test plan
- Reset released with din low, then one pulse of 8 high cycles:
  - pulse_out is high for one cycle, one cycle after the rise.
  - width=8, width_valid pulse, err_short=0, err_long=0, good_cnt=1.
- Pulses of widths 6, 7, 9 and 10 with one-cycle gaps:
  - Reports are err_short, good, good, err_long in that order.
  - good_cnt increases by 2.
  - The next pulse_out coincides with the falling edge of each width_valid.
- din held high for 300 cycles:
  - busy stays high throughout.
  - The report gives width=255 and err_long=1.
- din high at reset release for 5 cycles, then a normal 8-cycle pulse:
  - No report and no pulse_out for the first level.
  - The second pulse reports width=8.
- reset_n asserted on the 4th cycle of a pulse:
  - All outputs go to 0 immediately.
  - The FSM enters ARM and produces no report until din has gone low and a new pulse begins.
- Counter wrap and clear, with CW=4:
  - 16 good pulses leave good_cnt at 0.
  - clr_cnt asserted on the same cycle as a good report leaves good_cnt at 0.
